img_stream_source: RTL and testbench

IMG_STREAM_SOURCE -- requirements
Module: img_stream_source

---
 rtl/img_stream_source.sv | 179 +++++++++++++++++
 tb/tb_img_stream_source.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_source.sv
// Synthetic camera-style video source: vsync / href / 8-bit grey pixel stream
// with four selectable test patterns and a running frame counter.
module img_stream_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 25,
    parameter int V_FRONT  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic [7:0] per_img_y,
    output logic       frame_done,
    output logic       busy
);

    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int V_MAX_AB = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX_CD = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX    = (V_MAX_AB > V_MAX_CD) ? V_MAX_AB : V_MAX_CD;
    localparam int COL_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int LINE_W   = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0]  COL_ZERO   = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]  COL_ONE    = COL_W'(1);
    localparam logic [LINE_W-1:0] LINE_ZERO  = {LINE_W{1'b0}};
    localparam logic [LINE_W-1:0] LINE_ONE   = LINE_W'(1);
    localparam logic [LINE_W-1:0] LAST_VS    = LINE_W'(V_SYNC - 1);
    localparam logic [LINE_W-1:0] LAST_VB    = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] LAST_VA    = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LAST_VF    = LINE_W'(V_FRONT - 1);
    localparam logic [31:0]       H_ACTIVE_U = 32'(H_ACTIVE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [COL_W-1:0]    col_r;
    logic [COL_W-1:0]    col_s;
    logic [LINE_W-1:0]   line_r;
    logic [LINE_W-1:0]   line_s;
    logic [LINE_W-1:0]   last_line_s;
    logic [1:0]          pat_r;
    logic [7:0]          frame_cnt_r;
    logic                col_wrap_s;
    logic                line_wrap_s;
    logic                start_s;
    logic                frame_end_s;
    logic                href_s;
    logic                done_s;
    logic [7:0]          y_s;

    // x/y are the active column and active line, truncated to 8 bits
    function automatic logic [7:0] pixel_f(input logic [1:0] sel,
                                           input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic [7:0] fc);
        logic [7:0] p;
        case (sel)
            2'd0:    p = x;
            2'd1:    p = y;
            2'd2:    p = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            2'd3:    p = fc;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    assign col_wrap_s  = (col_r == COL_LAST);
    assign line_wrap_s = col_wrap_s && (line_r == last_line_s);
    assign frame_end_s = (state_r == VFRONT) && line_wrap_s;

    // Terminal line index of the current vertical region
    always_comb begin
        case (state_r)
            VSYNC:   last_line_s = LAST_VS;
            VBACK:   last_line_s = LAST_VB;
            ACTIVE:  last_line_s = LAST_VA;
            VFRONT:  last_line_s = LAST_VF;
            default: last_line_s = LINE_ZERO;
        endcase
    end

    // Next column/line position and next FSM state
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        if (state_r == IDLE) begin
            col_s  = COL_ZERO;
            line_s = LINE_ZERO;
        end else if (col_wrap_s) begin
            col_s  = COL_ZERO;
            line_s = line_wrap_s ? LINE_ZERO : (line_r + LINE_ONE);
        end else begin
            col_s  = col_r + COL_ONE;
            line_s = line_r;
        end
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = VSYNC;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            VSYNC:  state_s = line_wrap_s ? VBACK  : VSYNC;
            VBACK:  state_s = line_wrap_s ? ACTIVE : VBACK;
            ACTIVE: state_s = line_wrap_s ? VFRONT : ACTIVE;
            VFRONT: begin
                // Back-to-back frames when enable is still requested
                if (line_wrap_s && enable) begin
                    state_s = VSYNC;
                    start_s = 1'b1;
                end else if (line_wrap_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = VFRONT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output values for the upcoming cycle, registered below
    always_comb begin
        href_s = (state_s == ACTIVE) && (32'(col_s) < H_ACTIVE_U);
        done_s = (state_s == VFRONT) && (line_s == LAST_VF) && (col_s == COL_LAST);
        if (href_s) begin
            y_s = pixel_f(pat_r, 8'(col_s), 8'(line_s), frame_cnt_r);
        end else begin
            y_s = 8'h00;
        end
    end

    // FSM, timing counters, latched pattern, frame counter and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            col_r           <= COL_ZERO;
            line_r          <= LINE_ZERO;
            pat_r           <= 2'd0;
            frame_cnt_r     <= 8'd0;
            per_frame_vsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_img_y       <= 8'h00;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            line_r  <= line_s;
            if (start_s) begin
                pat_r <= pattern_sel;
            end
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            per_frame_vsync <= (state_s == VSYNC);
            per_frame_href  <= href_s;
            per_img_y       <= y_s;
            frame_done      <= done_s;
            busy            <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_img_stream_source.sv
// Bench for img_stream_source: frame-cycle-index reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_img_stream_source;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int HT = HA + HB;
    localparam int FT = HT * (VS + VB + VA + VF);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       per_frame_vsync, per_frame_href, frame_done, busy;
    logic [7:0] per_img_y;

    logic       enable16 = 1'b0;
    logic [1:0] sel16 = 2'd0;
    logic       vsync16, href16, done16, busy16;
    logic [7:0] y16;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    img_stream_source #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                        .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_img_y(per_img_y), .frame_done(frame_done), .busy(busy)
    );

    img_stream_source #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(16),
                        .V_SYNC(1), .V_BACK(1), .V_FRONT(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .enable(enable16), .pattern_sel(sel16),
        .per_frame_vsync(vsync16), .per_frame_href(href16),
        .per_img_y(y16), .frame_done(done16), .busy(busy16)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: position inside the frame ----------------
    int         m_t = -1;      // cycle index within current frame, -1 when idle
    logic [1:0] m_pat = 2'd0;
    logic [7:0] m_fc = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= -1;
            m_pat <= 2'd0;
            m_fc  <= 8'd0;
        end else if (m_t < 0) begin
            if (enable) begin
                m_t   <= 0;
                m_pat <= pattern_sel;
            end
        end else if (m_t == FT - 1) begin
            m_fc <= m_fc + 8'd1;
            if (enable) begin
                m_t   <= 0;
                m_pat <= pattern_sel;
            end else begin
                m_t <= -1;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    function automatic void model_out(input int t, input int pat, input int fc,
                                      output int ev, output int eh, output int ey,
                                      output int efd, output int eb);
        int line, col, al;
        ev = 0; eh = 0; ey = 0; efd = 0; eb = 0;
        if (t >= 0) begin
            line = t / HT;
            col  = t % HT;
            al   = line - VS - VB;
            eb   = 1;
            ev   = (line < VS) ? 1 : 0;
            eh   = (al >= 0 && al < VA && col < HA) ? 1 : 0;
            efd  = (t == FT - 1) ? 1 : 0;
            if (eh == 1) begin
                case (pat)
                    0: ey = col % 256;
                    1: ey = al % 256;
                    2: ey = (((col / 8) % 2) != ((al / 8) % 2)) ? 255 : 0;
                    3: ey = fc;
                    default: ey = 0;
                endcase
            end
        end
    endfunction

    always @(negedge clk) begin : cmp
        int ev, eh, ey, efd, eb;
        model_out(m_t, int'(m_pat), int'(m_fc), ev, eh, ey, efd, eb);
        check("vsync", int'(per_frame_vsync), ev);
        check("href", int'(per_frame_href), eh);
        check("pixel", int'(per_img_y), ey);
        check("frame_done", int'(frame_done), efd);
        check("busy", int'(busy), eb);
    end

    // ---------------- observation for directed checks ----------------
    int         vs_cnt, href_cnt, fd_cnt, busy_cnt, vs_rise, last_rise, line_idx, x_idx;
    logic       vs_prev = 1'b0, href_prev = 1'b0;
    logic [7:0] img [0:VA-1][0:HA-1];
    int         intervals[$];
    logic [7:0] first_pix[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (per_frame_vsync && !vs_prev) begin
            vs_rise++;
            if (last_rise >= 0) intervals.push_back(cyc - last_rise);
            last_rise = cyc;
            line_idx = -1;
        end
        if (per_frame_href && !href_prev) begin
            line_idx++;
            x_idx = 0;
            if (line_idx == 0) first_pix.push_back(per_img_y);
        end
        if (per_frame_href) begin
            if (line_idx >= 0 && line_idx < VA && x_idx < HA) img[line_idx][x_idx] = per_img_y;
            x_idx++;
            href_cnt++;
        end
        vs_cnt   += int'(per_frame_vsync);
        fd_cnt   += int'(frame_done);
        busy_cnt += int'(busy);
        vs_prev   = per_frame_vsync;
        href_prev = per_frame_href;
    end

    int         line16 = -1, x16 = 0;
    logic       vs16_prev = 1'b0, href16_prev = 1'b0;
    logic [7:0] img16 [0:15][0:15];

    always @(negedge clk) begin
        if (vsync16 && !vs16_prev) line16 = -1;
        if (href16 && !href16_prev) begin
            line16++;
            x16 = 0;
        end
        if (href16) begin
            if (line16 >= 0 && line16 < 16 && x16 < 16) img16[line16][x16] = y16;
            x16++;
        end
        vs16_prev   = vsync16;
        href16_prev = href16;
    end

    task automatic clear_mon();
        vs_cnt = 0; href_cnt = 0; fd_cnt = 0; busy_cnt = 0; vs_rise = 0;
        last_rise = -1; line_idx = -1; x_idx = 0;
        intervals.delete();
        first_pix.delete();
    endtask

    task automatic pulse_enable();
        @(posedge clk); #2 enable = 1'b1;
        @(posedge clk); #2 enable = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (busy && n < budget);
        check(name, int'(busy), 0);
    endtask

    task automatic wait_rises(input int k, input int budget);
        int n = 0;
        while (vs_rise < k && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("rise_wait", (vs_rise >= k) ? 1 : 0, 1);
    endtask

    task automatic wait_href(input int k, input int budget);
        int n = 0;
        while (href_cnt < k && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("href_wait", (href_cnt >= k) ? 1 : 0, 1);
    endtask

    task automatic wait_line(input int k, input int budget);
        int n = 0;
        while (!(line_idx == k && per_frame_href) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("line_wait", (line_idx == k) ? 1 : 0, 1);
    endtask

    initial begin
        clear_mon();
        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_vsync", int'(per_frame_vsync), 0);
        check("rst_href", int'(per_frame_href), 0);
        check("rst_y", int'(per_img_y), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("idle_no_start", int'(busy), 0);
        check("idle_no_vsync", int'(per_frame_vsync), 0);

        // single frame, horizontal ramp
        clear_mon();
        pattern_sel = 2'd0;
        pulse_enable();
        wait_idle("single_idle", 200);
        check("single_vsync_cycles", vs_cnt, 12);
        check("single_href_cycles", href_cnt, 32);
        check("single_done_pulses", fd_cnt, 1);
        check("single_busy_cycles", busy_cnt, 84);
        for (int x = 0; x < HA; x++) check("ramp_line0", int'(img[0][x]), x);
        check("ramp_line3_x7", int'(img[3][7]), 7);

        // three back-to-back frames
        clear_mon();
        @(posedge clk); #2 enable = 1'b1;
        wait_rises(3, 400);
        enable = 1'b0;
        wait_idle("cont_idle", 200);
        check("cont_done_pulses", fd_cnt, 3);
        check("cont_rises", vs_rise, 3);
        check("cont_intervals", intervals.size(), 2);
        if (intervals.size() == 2) begin
            check("cont_period0", intervals[0], 84);
            check("cont_period1", intervals[1], 84);
        end
        check("cont_vsync_cycles", vs_cnt, 36);

        // vertical ramp
        clear_mon();
        pattern_sel = 2'd1;
        pulse_enable();
        wait_idle("vramp_idle", 200);
        for (int x = 0; x < HA; x++) check("vramp_line2", int'(img[2][x]), 2);
        check("vramp_line0", int'(img[0][3]), 0);

        // pattern change and enable drop during ACTIVE
        clear_mon();
        pattern_sel = 2'd1;
        @(posedge clk); #2 enable = 1'b1;
        wait_href(9, 200);
        pattern_sel = 2'd2;
        enable = 1'b0;
        wait_idle("mid_idle", 200);
        check("mid_busy_cycles", busy_cnt, 84);
        check("mid_done_pulses", fd_cnt, 1);
        check("mid_line3", int'(img[3][5]), 3);
        check("mid_line1", int'(img[1][0]), 1);
        repeat (100) @(negedge clk);
        #1;
        check("mid_no_restart", vs_rise, 1);
        check("mid_stays_idle", int'(busy), 0);

        // reset during active line 2, then frame-number pattern
        clear_mon();
        pattern_sel = 2'd0;
        @(posedge clk); #2 enable = 1'b1;
        wait_line(2, 200);
        rst_n = 1'b0;
        #1;
        check("arst_vsync", int'(per_frame_vsync), 0);
        check("arst_href", int'(per_frame_href), 0);
        check("arst_y", int'(per_img_y), 0);
        check("arst_done", int'(frame_done), 0);
        check("arst_busy", int'(busy), 0);
        pattern_sel = 2'd3;
        repeat (3) @(posedge clk);
        clear_mon();
        #2 rst_n = 1'b1;
        wait_rises(3, 400);
        enable = 1'b0;
        wait_idle("fnum_idle", 200);
        check("fnum_frames", first_pix.size(), 3);
        if (first_pix.size() == 3) begin
            check("fnum_frame0", int'(first_pix[0]), 0);
            check("fnum_frame1", int'(first_pix[1]), 1);
            check("fnum_frame2", int'(first_pix[2]), 2);
        end

        // checkerboard on a 16x16 active area
        sel16 = 2'd2;
        @(posedge clk); #2 enable16 = 1'b1;
        @(posedge clk); #2 enable16 = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk); #1;
                n++;
            end while (busy16 && n < 1000);
        end
        check("cb_idle", int'(busy16), 0);
        check("cb_x8_y0", int'(img16[0][8]), 255);
        check("cb_x8_y8", int'(img16[8][8]), 0);
        check("cb_x0_y0", int'(img16[0][0]), 0);
        check("cb_x0_y8", int'(img16[8][0]), 255);
        check("cb_x15_y15", int'(img16[15][15]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
